p251_mul: RTL and testbench

P251_MUL -- requirements
Module: p251_mul

---
 rtl/p251_pkg.sv | 19 +
 rtl/p251_add_mod.sv | 17 +
 rtl/p251_mul.sv | 99 +++++++++
 tb/tb_p251_mul.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/p251_pkg.sv
// rtl/p251_pkg.sv - shared constants, state type and operand reduction for the mod-251 multiplier
package p251_pkg;

    localparam int P251_MOD  = 251;
    localparam int P251_W    = 8;
    localparam int P251_ITER = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } p251_state_t;

    // Any 8-bit value is below 2*251, so a single conditional subtract reduces it.
    function automatic logic [P251_W-1:0] p251_reduce(input logic [P251_W-1:0] v);
        return (v >= P251_W'(P251_MOD)) ? v - P251_W'(P251_MOD) : v;
    endfunction

endpackage

// File: rtl/p251_add_mod.sv
// rtl/p251_add_mod.sv - combinational (a + b) mod 251 for operands already below 251
module p251_add_mod
    import p251_pkg::*;
(
    input  logic [P251_W-1:0] a,
    input  logic [P251_W-1:0] b,
    output logic [P251_W-1:0] y
);

    logic [P251_W:0] sum;
    logic [P251_W:0] sum_red;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign sum_red = sum - (P251_W+1)'(P251_MOD);
    assign y       = (sum >= (P251_W+1)'(P251_MOD)) ? sum_red[P251_W-1:0] : sum[P251_W-1:0];

endmodule

// File: rtl/p251_mul.sv
// rtl/p251_mul.sv - serial MSB-first A*B mod 251 multiplier; optional macro P251_MUL_ZERO_BYPASS_EN
module p251_mul
    import p251_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [P251_W-1:0] in_1,
    input  logic [P251_W-1:0] in_2,
    output logic [P251_W-1:0] out,
    output logic              done
);

    localparam int CW = $clog2(P251_ITER);

    p251_state_t       state, state_next;
    logic [P251_W-1:0] a_reg, b_reg, acc;
    logic [CW-1:0]     cnt;
    logic [P251_W-1:0] acc_dbl, acc_add, acc_next;
    logic              capture, step, last, zero_hit, b_bit;

    p251_add_mod u_dbl (.a(acc),     .b(acc),   .y(acc_dbl));
    p251_add_mod u_add (.a(acc_dbl), .b(a_reg), .y(acc_add));

    assign b_bit    = b_reg[CW'(P251_ITER-1) - cnt];
    assign acc_next = b_bit ? acc_add : acc_dbl;

`ifdef P251_MUL_ZERO_BYPASS_EN
    // Zero operand finishes on the first BUSY edge, so done still trails start by one cycle.
    assign zero_hit = (a_reg == '0) || (b_reg == '0);
`else
    assign zero_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (zero_hit || cnt == CW'(P251_ITER-1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            out   <= '0;
            done  <= 1'b0;
        end else begin
            done <= (state_next == DONE);
            if (capture) begin
                a_reg <= p251_reduce(in_1);
                b_reg <= p251_reduce(in_2);
                acc   <= '0;
                cnt   <= '0;
            end else if (step) begin
                acc <= acc_next;
                cnt <= cnt + CW'(1);
                if (last) begin
                    out <= zero_hit ? '0 : acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_p251_mul.sv
// tb/tb_p251_mul.sv - randomized self-checking bench for p251_mul against an arithmetic model
module tb_p251_mul;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] in_1;
    logic [7:0] in_2;
    logic [7:0] out;
    logic       done;

    int checks;
    int failures;

    p251_mul dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in_1  (in_1),
        .in_2  (in_2),
        .out   (out),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_mul(input int a, input int b);
        return ((a % 251) * (b % 251)) % 251;
    endfunction

    function automatic int model_lat(input int a, input int b);
`ifdef P251_MUL_ZERO_BYPASS_EN
        if ((a % 251) == 0 || (b % 251) == 0) return 1;
`endif
        return 8;
    endfunction

    // One start pulse, then wait (bounded) for done; lat = -1 if it never came.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [7:0] res);
        @(negedge clk);
        in_1  = a;
        in_2  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_1  = 8'($urandom);
        in_2  = 8'($urandom);
        lat   = -1;
        res   = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                res = out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        in_1  = 8'd0;
        in_2  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out !== 8'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: out=%0d done=%0b required out=0 done=0", out, done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int         lat;
        logic [7:0] res;
        int         va [6] = '{1, 250, 100, 255, 0, 77};
        int         vb [6] = '{20, 250, 100, 2, 77, 0};
        for (int i = 0; i < 6; i++) begin
            run_op(8'(va[i]), 8'(vb[i]), lat, res);
            checks++;
            if (lat !== model_lat(va[i], vb[i]) || res !== 8'(model_mul(va[i], vb[i]))) begin
                failures++;
                $display("FAIL directed_%0dx%0d: out=%0d latency=%0d required out=%0d latency=%0d",
                         va[i], vb[i], res, lat, model_mul(va[i], vb[i]), model_lat(va[i], vb[i]));
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL done_width_%0d: done=%0b required 0 one cycle after pulse", i, done);
            end
        end
    endtask

    task automatic test_random();
        int         lat;
        logic [7:0] res;
        int         a, b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            if (i % 10 == 0) a = 251;
            run_op(8'(a), 8'(b), lat, res);
            checks++;
            if (lat !== model_lat(a, b) || res !== 8'(model_mul(a, b))) begin
                failures++;
                $display("FAIL random_%0dx%0d: out=%0d latency=%0d required out=%0d latency=%0d",
                         a, b, res, lat, model_mul(a, b), model_lat(a, b));
            end
        end
    endtask

    task automatic test_busy_start_ignored();
        int         pulses, first_lat;
        logic [7:0] first_res;
        @(negedge clk);
        in_1  = 8'd37;
        in_2  = 8'd203;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pulses    = 0;
        first_lat = -1;
        first_res = 'x;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                in_1  = 8'd5;
                in_2  = 8'd6;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (first_lat < 0) begin
                    first_lat = k;
                    first_res = out;
                end
            end
        end
        checks++;
        if (pulses !== 1 || first_lat !== 8 || first_res !== 8'(model_mul(37, 203))) begin
            failures++;
            $display("FAIL busy_start_ignored: pulses=%0d latency=%0d out=%0d required pulses=1 latency=8 out=%0d",
                     pulses, first_lat, first_res, model_mul(37, 203));
        end
    endtask

    task automatic test_mid_reset();
        int         lat;
        logic [7:0] res;
        @(negedge clk);
        in_1  = 8'd123;
        in_2  = 8'd45;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out !== 8'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_async: out=%0d done=%0b required out=0 done=0", out, done);
        end
        @(negedge clk);
        rst = 1'b0;
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) lat = k;
        end
        checks++;
        if (lat !== -1) begin
            failures++;
            $display("FAIL mid_reset_no_done: done seen at cycle=%0d required none", lat);
        end
        run_op(8'd7, 8'd9, lat, res);
        checks++;
        if (lat !== 8 || res !== 8'd63) begin
            failures++;
            $display("FAIL after_reset_7x9: out=%0d latency=%0d required out=63 latency=8", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int         lat1, lat2;
        logic [7:0] res1, res2;
        @(negedge clk);
        in_1  = 8'd199;
        in_2  = 8'd173;
        start = 1'b1;
        @(posedge clk);
        #1;
        in_1 = 8'd88;
        in_2 = 8'd240;
        lat1 = -1;
        lat2 = -1;
        res1 = 'x;
        res2 = 'x;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (lat1 < 0) begin
                    lat1 = k;
                    res1 = out;
                end else begin
                    lat2 = k - lat1;
                    res2 = out;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (lat1 !== 8 || res1 !== 8'(model_mul(199, 173))) begin
            failures++;
            $display("FAIL b2b_first: out=%0d latency=%0d required out=%0d latency=8",
                     res1, lat1, model_mul(199, 173));
        end
        checks++;
        if (lat2 !== 9 || res2 !== 8'(model_mul(88, 240))) begin
            failures++;
            $display("FAIL b2b_second: out=%0d gap=%0d required out=%0d gap=9",
                     res2, lat2, model_mul(88, 240));
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_random();
        test_busy_start_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
